// File: rtl/load_store_pkg.sv
// Shared load/store definitions: size encodings, byte-mask helper,
// load-path state encoding and the latched load context.
package load_store_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BE_W   = XLEN / 8;
  localparam int unsigned BUF_W  = 2 * XLEN;
  localparam int unsigned WORD_W = XLEN - 2;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    LD_IDLE      = 2'd0,
    LD_REQ_LOW   = 2'd1,
    LD_REQ_HIGH  = 2'd2,
    LD_WAIT_DATA = 2'd3
  } load_state_e;

  // Load parameters held for the life of one load
  typedef struct packed {
    logic [1:0] offset;
    logic [1:0] size;
    logic       is_signed;
    logic [3:0] mask_hi;
  } load_ctx_t;

  // Byte mask over two consecutive words; bits [7:4] select the high word.
  // Reserved size 3 behaves as a word.
  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [1:0] offset);
    logic [7:0] base;
    case (size)
      SIZE_BYTE: base = 8'h01;
      SIZE_HALF: base = 8'h03;
      default:   base = 8'h0F;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Data memory read port of the load unit.
//   mem_addr            word-aligned address
//   mem_byte_enable     bytes needed from the addressed word
//   mem_read_req        request valid
//   mem_ready           memory accepts the request at the clock edge
//   mem_read_data       response data
//   mem_read_data_valid response strobe (in order)
interface load_unit_if;

  logic [load_store_pkg::XLEN-1:0] mem_addr;
  logic [load_store_pkg::BE_W-1:0] mem_byte_enable;
  logic                            mem_read_req;
  logic                            mem_ready;
  logic [load_store_pkg::XLEN-1:0] mem_read_data;
  logic                            mem_read_data_valid;

  modport master (
    output mem_addr, mem_byte_enable, mem_read_req,
    input  mem_ready, mem_read_data, mem_read_data_valid
  );

  modport slave (
    input  mem_addr, mem_byte_enable, mem_read_req,
    output mem_ready, mem_read_data, mem_read_data_valid
  );

endinterface

// File: rtl/load_align.sv
// Extracts a byte/half/word from the two-word response buffer and extends it.
//   buffer    {high word, low word} as returned by memory
//   offset    byte offset of the load within the low word
//   size      0 byte, 1 half, 2/3 word
//   is_signed sign-extend request (honoured only with LOAD_UNIT_SIGN_EXTEND_EN)
//   data_c    extended result
// Macro LOAD_UNIT_SIGN_EXTEND_EN enables sign extension; otherwise zero-extend.
module load_align
  import load_store_pkg::*;
(
  input  logic [BUF_W-1:0] buffer,
  input  logic [1:0]       offset,
  input  logic [1:0]       size,
  input  logic             is_signed,
  output logic [XLEN-1:0]  data_c
);

  logic [XLEN-1:0] shifted;

  assign shifted = XLEN'(buffer >> {offset, 3'b000});

`ifdef LOAD_UNIT_SIGN_EXTEND_EN
  logic fill;

  // Fill bit is the top bit of the loaded quantity for signed sub-word loads
  always_comb begin
    fill = 1'b0;
    if (is_signed) begin
      case (size)
        SIZE_BYTE: fill = shifted[7];
        SIZE_HALF: fill = shifted[15];
        default:   fill = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (size)
      SIZE_BYTE: data_c = {{24{fill}}, shifted[7:0]};
      SIZE_HALF: data_c = {{16{fill}}, shifted[15:0]};
      default:   data_c = shifted;
    endcase
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;

  always_comb begin
    case (size)
      SIZE_BYTE: data_c = {24'b0, shifted[7:0]};
      SIZE_HALF: data_c = {16'b0, shifted[15:0]};
      default:   data_c = shifted;
    endcase
  end
`endif

endmodule

// File: rtl/load_unit.sv
// CPU load path: issues one or two aligned word reads per load, merges the
// responses and returns the aligned, extended result.
//   clk, reset_n     clock, synchronous active-low reset
//   read_ready       idle, a load can be accepted
//   read_req/addr/size/signed   load request
//   read_data/read_data_valid   result and one-cycle completion pulse
//   mem              data memory read port (load_unit_if.master)
// Macro LOAD_UNIT_SIGN_EXTEND_EN enables read_signed (see load_align).
module load_unit
  import load_store_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  output logic            read_ready,
  input  logic            read_req,
  input  logic [XLEN-1:0] read_addr,
  input  logic [1:0]      read_size,
  input  logic            read_signed,
  output logic [XLEN-1:0] read_data,
  output logic            read_data_valid,
  load_unit_if.master     mem
);

  load_state_e     state_q, state_d;
  load_ctx_t       ctx_q, ctx_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [BE_W-1:0] be_q, be_d;
  logic            req_q, req_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            valid_q, valid_d;

  logic [7:0]      mask_in;
  logic            need_high;
  logic            all_resp;
  logic            resp_fire;
  logic [XLEN-1:0] align_data_c;

  assign mask_in   = byte_mask(read_size, read_addr[1:0]);
  assign need_high = |ctx_q.mask_hi;
  assign all_resp  = cnt_q >= (need_high ? 2'd2 : 2'd1);
  // Responses arriving while idle are stale (e.g. from before a reset)
  assign resp_fire = mem.mem_read_data_valid && (state_q != LD_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= LD_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_IDLE:      if (read_req)      state_d = LD_REQ_LOW;
      LD_REQ_LOW:   if (mem.mem_ready) state_d = need_high ? LD_REQ_HIGH : LD_WAIT_DATA;
      LD_REQ_HIGH:  if (mem.mem_ready) state_d = LD_WAIT_DATA;
      LD_WAIT_DATA: if (all_resp)      state_d = LD_IDLE;
      default:                         state_d = LD_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    ctx_d   = ctx_q;
    addr_d  = addr_q;
    be_d    = be_q;
    req_d   = req_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;

    if (resp_fire) begin
      if (cnt_q == 2'd0) buf_d[XLEN-1:0]     = mem.mem_read_data;
      else               buf_d[BUF_W-1:XLEN] = mem.mem_read_data;
      cnt_d = cnt_q + 2'd1;
    end

    case (state_q)
      LD_IDLE: begin
        if (read_req) begin
          ctx_d.offset    = read_addr[1:0];
          ctx_d.size      = read_size;
          ctx_d.is_signed = read_signed;
          ctx_d.mask_hi   = mask_in[7:4];
          addr_d          = {read_addr[XLEN-1:2], 2'b00};
          be_d            = mask_in[3:0];
          req_d           = 1'b1;
          cnt_d           = 2'd0;
        end
      end
      LD_REQ_LOW: begin
        if (mem.mem_ready) begin
          if (need_high) begin
            // Word field wraps naturally at the top of the address space
            addr_d = {addr_q[XLEN-1:2] + WORD_W'(1), 2'b00};
            be_d   = ctx_q.mask_hi;
          end else begin
            req_d  = 1'b0;
          end
        end
      end
      LD_REQ_HIGH: begin
        if (mem.mem_ready) req_d = 1'b0;
      end
      LD_WAIT_DATA: begin
        if (all_resp) begin
          data_d  = align_data_c;
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctx_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      req_q   <= 1'b0;
      buf_q   <= '0;
      cnt_q   <= 2'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ctx_q   <= ctx_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      req_q   <= req_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  load_align u_align (
    .buffer    (buf_q),
    .offset    (ctx_q.offset),
    .size      (ctx_q.size),
    .is_signed (ctx_q.is_signed),
    .data_c    (align_data_c)
  );

  assign read_ready          = (state_q == LD_IDLE);
  assign read_data           = data_q;
  assign read_data_valid     = valid_q;
  assign mem.mem_addr        = addr_q;
  assign mem.mem_byte_enable = be_q;
  assign mem.mem_read_req    = req_q;

endmodule

// File: doc/load_unit.md
# load_unit

CPU-side load path. Accepts a byte, halfword or word read at any byte address and issues one or two aligned 32-bit word reads to the data memory port. When a load straddles a word boundary, it merges the two returned words, then shifts, masks and extends the result. It is the read counterpart of the CPU store path and shares that path's memory address and byte-enable conventions.

## Interface
Parameters: none.
- `clk`  in  1  clock
- `reset_n`  in  1  reset; synchronous, active-low
- `read_ready`  out  1  high when IDLE; a load can be accepted
- `read_req`  in  1  load request; sampled only while `read_ready`
- `read_addr`  in  32  byte address
- `read_size`  in  2  0 byte, 1 half, 2 word, 3 reserved (treated as word)
- `read_signed`  in  1  sign-extend result (see Configuration)
- `read_data`  out  32  load result; holds until the next completion
- `read_data_valid`  out  1  one-cycle pulse when `read_data` updates
- `mem_ready`  in  1  memory accepts the current request at the clock edge
- `mem_addr`  out  32  word-aligned address (bits [1:0] always 0)
- `mem_byte_enable`  out  4  bytes needed from the current word
- `mem_read_req`  out  1  request valid
- `mem_read_data`  in  32  response data
- `mem_read_data_valid`  in  1  response strobe; responses arrive in order, at least 1 cycle after acceptance

## Operation
- Mask = 0001/0011/1111 by size. Place it in 8-bit space and shift left by `read_addr[1:0]`. If mask[7:4] ≠ 0, the load needs a high word.
- States:
  - IDLE:
    - On `read_req`: latch addr[1:0], size, signed and mask.
    - Register `mem_addr = {read_addr[31:2],2'b0}`, `mem_byte_enable = mask[3:0]`, `mem_read_req = 1`.
    - Go to REQ_LOW.
  - REQ_LOW, on `mem_ready`:
    - No high word: clear `mem_read_req` and go to WAIT_DATA.
    - High word needed: set `mem_addr` word field +1 (mod 2^30, so 0xFFFFFFFC wraps to 0x00000000), set `mem_byte_enable = mask[7:4]`, and go to REQ_HIGH.
  - REQ_HIGH, on `mem_ready`: clear `mem_read_req` and go to WAIT_DATA.
  - WAIT_DATA: when all needed responses are counted, register the result, pulse `read_data_valid` and go to IDLE.
- Responses are captured in every non-IDLE state, including REQ_HIGH.
  - The first response goes to buffer[31:0], the second to buffer[63:32].
  - A 2-bit counter tracks responses received.
  - If the final response arrives in the same cycle as the REQ_HIGH acceptance, completion still follows on the next edge.
- Result: take buffer >> {addr[1:0],3'b0}, keep the low 8/16/32 bits, then zero- or sign-extend from bit 7/15.
- `mem_read_data_valid` in IDLE is ignored.
- `mem_addr`, `mem_byte_enable` and `mem_read_req` are registered and stable while waiting on `mem_ready`.

## Timing
- Reset values: `read_data` 0, `read_data_valid` 0, `mem_addr` 0, `mem_byte_enable` 0, `mem_read_req` 0, buffer 0, counter 0, state IDLE.
- `read_ready` is combinational from state, so it is 1 after reset.
- Minimum single-word latency, with `read_req` sampled at edge T:
  - `mem_read_req` high after T.
  - Accepted at T+1.
  - Response at T+2.
  - `read_data_valid` high in the cycle after edge T+3.
- Split load: +1 cycle minimum.
- Backpressure: while `mem_ready` is low, the request holds indefinitely with no change.
- `reset_n` low at an edge, in any state, returns everything to reset values. Responses still in flight from before reset are ignored, because they arrive in IDLE.
- `read_data_valid` is never high for more than one cycle. Back-to-back loads: the next `read_req` can be accepted in the cycle `read_data_valid` is high.

## Configuration
- `LOAD_UNIT_SIGN_EXTEND_EN` defined: `read_signed` selects sign extension.
- `LOAD_UNIT_SIGN_EXTEND_EN` undefined: the port remains but is ignored. All results are zero-extended and the extension logic is omitted.

## Structure
- Package `load_store_pkg`:
  - size encoding constants (SIZE_BYTE/HALF/WORD)
  - the byte-mask function shared with the store path
  - load state encoding
- Sub-module `load_align`: combinational extract, mask and extend from the 64-bit buffer, addr[1:0], size and signed. Sign-extension logic sits inside the `LOAD_UNIT_SIGN_EXTEND_EN` guard.

## Test plan
- Aligned word, 0x1000, mem returns 0xDEADBEEF with `mem_ready` = 1: one request, byte_enable 1111, `read_data` = 0xDEADBEEF.
- Signed byte at 0x1002, word 0x0080_0000:
  - `read_data` = 0xFFFFFF80 with the macro defined.
  - `read_data` = 0x00000080 without it.
- Straddling half at 0x1003, words 0x11000000 then 0x00000022:
  - two requests: 0x1000/1000, then 0x1004/0001
  - `read_data` = 0x00002211
- Wrap: word at 0xFFFFFFFE gives requests 0xFFFFFFFC/1100, then 0x00000000/0011.
- Backpressure: `mem_ready` low for 5 cycles in REQ_LOW and REQ_HIGH. Address and enables stay stable and completion is correct; a response arriving during REQ_HIGH is captured.
- Reset asserted in WAIT_DATA, then a late `mem_read_data_valid`: outputs are at reset values, no `read_data_valid`, and `read_ready` = 1.
